// File: rtl/sdram_apb_csr_bank_if.sv
// sdram_apb_csr_bank_if: APB slave bus bundle for the SDRAM CSR bank
interface sdram_apb_csr_bank_if #(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/sdram_apb_csr_bank.sv
// sdram_apb_csr_bank: APB CSR bank with commit handshake, privilege protect and power-up delay
module sdram_apb_csr_bank #(
  parameter int                              PADDR_SIZE     = 8,
  parameter int                              PDATA_SIZE     = 32,
  parameter int                              NUM_CSR        = 4,
  parameter logic [NUM_CSR*PDATA_SIZE-1:0]   CSR_RESET      = '0,
  parameter int                              INIT_DLY_CNT   = 2500,
  parameter int                              COMMIT_TIMEOUT = 64
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  sdram_apb_csr_bank_if.slave           apb,
  output logic [NUM_CSR*PDATA_SIZE-1:0] csr_o,
  input  logic [PDATA_SIZE-1:0]         status_i,
  output logic                          commit_req_o,
  input  logic                          commit_ack_i,
  output logic                          init_done_o
);
  localparam int NB = PDATA_SIZE / 8;
  localparam int AW = $clog2(NB);
  localparam int IW = PADDR_SIZE - AW;
  localparam int TW = $clog2(COMMIT_TIMEOUT + 1);
  localparam int DW = $clog2(INIT_DLY_CNT + 1);
  typedef enum logic [1:0] {IDLE, WRITE, COMMIT, DONE} state_t;
  state_t                               state_q, state_d;
  logic [NUM_CSR-1:0][PDATA_SIZE-1:0]   csr_q;
  logic [IW-1:0]                        idx, widx_q;
  logic [TW-1:0]                        tcnt_q;
  logic [DW-1:0]                        icnt_q;
  logic [PDATA_SIZE-1:0]                rd_data, wmask, pp_mask, prdata_q;
  logic                                 to_q, err, setup, access, wr_en, tmo;
  assign idx     = apb.PADDR[PADDR_SIZE-1:AW];
  assign setup   = apb.PSEL & ~apb.PENABLE;
  assign access  = apb.PSEL & apb.PENABLE;
  assign wr_en   = (state_q == WRITE) && access;
  assign tmo     = tcnt_q == TW'(COMMIT_TIMEOUT - 1);
  assign pp_mask = {~init_done_o, {(PDATA_SIZE-1){1'b0}}};
  assign err = (csr_q[0][PDATA_SIZE-1] && !apb.PPROT[0]) || (32'(idx) > NUM_CSR) ||
               (apb.PWRITE && 32'(idx) == NUM_CSR);
  always_comb begin
    rd_data = {init_done_o, status_i[PDATA_SIZE-2:0]};
    for (int k = 0; k < NUM_CSR; k++) rd_data = (idx == IW'(k)) ? csr_q[k] : rd_data;
  end
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) wmask[8*b +: 8] = {8{apb.PSTRB[b]}};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (setup && apb.PWRITE && !err) ? WRITE : IDLE;
      WRITE:   state_d = !apb.PSEL ? IDLE : apb.PENABLE ? COMMIT : WRITE;
      COMMIT:  state_d = (commit_ack_i || tmo) ? DONE : COMMIT;
      default: state_d = IDLE;
    endcase
  end
  assign apb.PREADY   = (state_q == IDLE) || (state_q == DONE);
  assign apb.PSLVERR  = (state_q == DONE) ? to_q : ((state_q == IDLE) && access && err);
  assign apb.PRDATA   = prdata_q;
  assign commit_req_o = state_q == COMMIT;
  assign csr_o        = csr_q;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      csr_q       <= CSR_RESET;
      widx_q      <= '0;
      tcnt_q      <= '0;
      to_q        <= 1'b0;
      prdata_q    <= '0;
      icnt_q      <= DW'(INIT_DLY_CNT);
      init_done_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) widx_q <= idx;
      tcnt_q <= (state_q == COMMIT) ? tcnt_q + TW'(1) : '0;
      if (state_q == COMMIT) to_q <= !commit_ack_i;
      prdata_q <= (state_q == IDLE && setup && !apb.PWRITE && !err) ? rd_data : '0;
      // PP in CSR0 cannot be raised until the power-up delay has elapsed
      for (int k = 0; k < NUM_CSR; k++)
        if (wr_en && widx_q == IW'(k))
          csr_q[k] <= (csr_q[k] & ~wmask) |
                      (apb.PWDATA & wmask & ((k == 0) ? ~pp_mask : {PDATA_SIZE{1'b1}}));
      icnt_q      <= (icnt_q != '0) ? icnt_q - DW'(1) : icnt_q;
      init_done_o <= init_done_o | (icnt_q == '0);
    end
  end
endmodule

// File: tb/tb_sdram_apb_csr_bank.sv
// tb_sdram_apb_csr_bank: directed checks of the APB CSR bank write/commit/error behaviour
module tb_sdram_apb_csr_bank;
  localparam logic [127:0] CSR_RST = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
  logic         PCLK, PRESETn;
  logic [127:0] csr_o;
  logic [31:0]  status;
  logic         commit_req, commit_ack, init_done, ack_en, ack_force;
  int           n_cmp = 0, n_bad = 0;
  sdram_apb_csr_bank_if #(.PADDR_SIZE(8), .PDATA_SIZE(32)) bus ();
  sdram_apb_csr_bank #(
    .PADDR_SIZE(8), .PDATA_SIZE(32), .NUM_CSR(4), .CSR_RESET(CSR_RST),
    .INIT_DLY_CNT(10), .COMMIT_TIMEOUT(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus), .csr_o(csr_o), .status_i(status),
    .commit_req_o(commit_req), .commit_ack_i(commit_ack), .init_done_o(init_done)
  );
  assign commit_ack = ack_force | (ack_en & commit_req);
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  task automatic bus_idle();
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0;
    bus.PSTRB = '0; bus.PPROT = '0; bus.PWDATA = '0;
  endtask
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic e, output int w, output int c);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = a;
    bus.PWDATA = d; bus.PSTRB = s; bus.PPROT = p;
    @(posedge PCLK); #1 bus.PENABLE = 1;
    w = 0; c = 0; e = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (bus.PREADY) begin e = bus.PSLVERR; break; end
      w++;
      if (commit_req) c++;
    end
    @(posedge PCLK); #1 bus_idle();
  endtask
  task automatic apb_read(input logic [7:0] a, input logic [2:0] p,
                          output logic [31:0] d, output logic e, output int w);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a; bus.PPROT = p;
    @(posedge PCLK); #1 bus.PENABLE = 1;
    w = 0; e = 1'bx; d = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (bus.PREADY) begin e = bus.PSLVERR; d = bus.PRDATA; break; end
      w++;
    end
    @(posedge PCLK); #1 bus_idle();
  endtask
  task automatic test_reset();
    int cyc;
    PRESETn = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    n_cmp++; if (bus.PREADY !== 1'b1) begin n_bad++; $display("FAIL rst_pready: got %b want 1", bus.PREADY); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr: got %b want 0", bus.PSLVERR); end
    n_cmp++; if (bus.PRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_prdata: got %h want 0", bus.PRDATA); end
    n_cmp++; if (commit_req !== 1'b0) begin n_bad++; $display("FAIL rst_commit_req: got %b want 0", commit_req); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    n_cmp++; if (csr_o !== CSR_RST) begin n_bad++; $display("FAIL rst_csr: got %h want %h", csr_o, CSR_RST); end
    @(posedge PCLK); #1 PRESETn = 1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge PCLK); #1 cyc++;
      if (init_done) break;
    end
    n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL init_delay: got %0d cycles want 11", cyc); end
  endtask
  task automatic test_strobe_write();
    logic e; int w, c; logic [31:0] d;
    apb_write(8'h04, 32'hA5A5_5A5A, 4'b0101, 3'b000, e, w, c);
    n_cmp++; if (csr_o[63:32] !== 32'h00A5_005A) begin n_bad++; $display("FAIL strb_csr1: got %h want 00a5005a", csr_o[63:32]); end
    n_cmp++; if (w !== 2) begin n_bad++; $display("FAIL strb_wait: got %0d want 2", w); end
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL strb_commit: got %0d want 1", c); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL strb_err: got %b want 0", e); end
    apb_read(8'h06, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h00A5_005A) begin n_bad++; $display("FAIL rd_lowbits: got %h want 00a5005a", d); end
    n_cmp++; if (w !== 0 || e !== 1'b0) begin n_bad++; $display("FAIL rd_zero_wait: got w=%0d e=%b want 0 0", w, e); end
    apb_read(8'h08, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_csr2_reset: got %h want 12345678", d); end
  endtask
  task automatic test_errors();
    logic e; int w, c; logic [31:0] d; logic [127:0] snap;
    apb_read(8'h10, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h8F0F_1234 || e !== 1'b0) begin n_bad++; $display("FAIL rd_status: got %h e=%b want 8f0f1234 e=0", d, e); end
    apb_read(8'h14, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h0 || e !== 1'b1 || w !== 0) begin n_bad++; $display("FAIL rd_unmapped: got %h e=%b w=%0d want 0 1 0", d, e, w); end
    apb_read(8'h3C, 3'b001, d, e, w);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL rd_idx15: got %h e=%b want 0 1", d, e); end
    snap = csr_o;
    apb_write(8'h10, 32'hFFFF_FFFF, 4'b1111, 3'b001, e, w, c);
    n_cmp++; if (e !== 1'b1 || w !== 0 || c !== 0) begin n_bad++; $display("FAIL wr_status: got e=%b w=%0d c=%0d want 1 0 0", e, w, c); end
    n_cmp++; if (csr_o !== snap) begin n_bad++; $display("FAIL wr_status_csr: got %h want %h", csr_o, snap); end
  endtask
  task automatic test_pp();
    logic e; int w, c; logic [31:0] d;
    apb_write(8'h00, 32'h8000_0001, 4'b1111, 3'b000, e, w, c);
    n_cmp++; if (e !== 1'b0 || csr_o[31:0] !== 32'h8000_0001) begin n_bad++; $display("FAIL pp_set: got %h e=%b want 80000001 0", csr_o[31:0], e); end
    apb_read(8'h00, 3'b000, d, e, w);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0 || w !== 0) begin n_bad++; $display("FAIL pp_unpriv_rd: got %h e=%b w=%0d want 0 1 0", d, e, w); end
    apb_read(8'h00, 3'b001, d, e, w);
    n_cmp++; if (e !== 1'b0 || d !== 32'h8000_0001) begin n_bad++; $display("FAIL pp_priv_rd: got %h e=%b want 80000001 0", d, e); end
    apb_write(8'h04, 32'hFFFF_FFFF, 4'b1111, 3'b000, e, w, c);
    n_cmp++; if (e !== 1'b1 || c !== 0 || csr_o[63:32] !== 32'h00A5_005A) begin n_bad++; $display("FAIL pp_unpriv_wr: got %h e=%b c=%0d want 00a5005a 1 0", csr_o[63:32], e, c); end
    apb_write(8'h00, 32'h0, 4'b1111, 3'b001, e, w, c);
    n_cmp++; if (e !== 1'b0 || csr_o[31:0] !== 32'h0) begin n_bad++; $display("FAIL pp_clear: got %h e=%b want 0 0", csr_o[31:0], e); end
  endtask
  task automatic test_timeout();
    logic e; int w, c; logic [31:0] d;
    ack_en = 0;
    apb_write(8'h0C, 32'hDEAD_BEEF, 4'b1111, 3'b000, e, w, c);
    ack_en = 1;
    n_cmp++; if (c !== 8) begin n_bad++; $display("FAIL to_commit_cycles: got %0d want 8", c); end
    n_cmp++; if (w !== 9) begin n_bad++; $display("FAIL to_wait: got %0d want 9", w); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", e); end
    n_cmp++; if (csr_o[127:96] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_csr3: got %h want deadbeef", csr_o[127:96]); end
    apb_read(8'h0C, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin n_bad++; $display("FAIL to_readback: got %h e=%b want deadbeef 0", d, e); end
  endtask
  task automatic test_back_to_back();
    logic e; int w, c;
    ack_force = 1;
    apb_write(8'h08, 32'h1122_3344, 4'b1100, 3'b000, e, w, c);
    n_cmp++; if (csr_o[95:64] !== 32'h1122_5678 || w !== 2 || c !== 1 || e !== 1'b0) begin n_bad++; $display("FAIL b2b_first: got %h w=%0d c=%0d e=%b want 11225678 2 1 0", csr_o[95:64], w, c, e); end
    apb_write(8'h04, 32'hCAFE_F00D, 4'b0011, 3'b000, e, w, c);
    n_cmp++; if (csr_o[63:32] !== 32'h00A5_F00D || w !== 2 || c !== 1 || e !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got %h w=%0d c=%0d e=%b want 00a5f00d 2 1 0", csr_o[63:32], w, c, e); end
    ack_force = 0;
  endtask
  task automatic test_psel_drop();
    logic e; int w, c; logic [31:0] d;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 8'h08;
    bus.PWDATA = 32'hFFFF_FFFF; bus.PSTRB = 4'b1111; bus.PPROT = 3'b000;
    @(posedge PCLK); #1 bus_idle();
    c = 0;
    repeat (4) begin @(negedge PCLK); if (commit_req) c++; end
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL drop_commit: got %0d want 0", c); end
    n_cmp++; if (csr_o[95:64] !== 32'h1122_5678 || bus.PREADY !== 1'b1) begin n_bad++; $display("FAIL drop_state: got %h rdy=%b want 11225678 1", csr_o[95:64], bus.PREADY); end
    @(posedge PCLK); #1;
    apb_read(8'h08, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h1122_5678 || w !== 0) begin n_bad++; $display("FAIL drop_read: got %h w=%0d want 11225678 0", d, w); end
  endtask
  task automatic test_reset_in_commit();
    logic e; int w; logic [31:0] d; logic seen;
    ack_en = 0; seen = 0;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 8'h08;
    bus.PWDATA = 32'hFFFF_FFFF; bus.PSTRB = 4'b1111; bus.PPROT = 3'b000;
    @(posedge PCLK); #1 bus.PENABLE = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (commit_req) begin seen = 1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rc_reach_commit: got %b want 1", seen); end
    #1 PRESETn = 0;
    #1;
    n_cmp++; if (commit_req !== 1'b0 || bus.PREADY !== 1'b1) begin n_bad++; $display("FAIL rc_abort: got req=%b rdy=%b want 0 1", commit_req, bus.PREADY); end
    n_cmp++; if (csr_o !== CSR_RST) begin n_bad++; $display("FAIL rc_csr: got %h want %h", csr_o, CSR_RST); end
    bus_idle();
    ack_en = 1;
    @(posedge PCLK); #1 PRESETn = 1;
    apb_read(8'h08, 3'b000, d, e, w);
    n_cmp++; if (d !== 32'h1234_5678 || e !== 1'b0 || w !== 0) begin n_bad++; $display("FAIL rc_idle_read: got %h e=%b w=%0d want 12345678 0 0", d, e, w); end
  endtask
  task automatic test_pp_pre_init();
    logic e; int w, c;
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL pre_init_flag: got %b want 0", init_done); end
    apb_write(8'h00, 32'hFFFF_FFFF, 4'b1111, 3'b001, e, w, c);
    n_cmp++; if (csr_o[31:0] !== 32'h7FFF_FFFF || e !== 1'b0) begin n_bad++; $display("FAIL pre_init_pp: got %h e=%b want 7fffffff 0", csr_o[31:0], e); end
    for (int i = 0; i < 20 && !init_done; i++) @(posedge PCLK);
    #1;
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_wait: got %b want 1", init_done); end
    apb_write(8'h00, 32'hFFFF_FFFF, 4'b1000, 3'b001, e, w, c);
    n_cmp++; if (csr_o[31:0] !== 32'hFFFF_FFFF || e !== 1'b0) begin n_bad++; $display("FAIL post_init_pp: got %h e=%b want ffffffff 0", csr_o[31:0], e); end
  endtask
  initial begin
    bus_idle();
    PRESETn = 0; ack_en = 1; ack_force = 0; status = 32'h0F0F_1234;
    test_reset();
    test_strobe_write();
    test_errors();
    test_pp();
    test_timeout();
    test_back_to_back();
    test_psel_drop();
    test_reset_in_commit();
    test_pp_pre_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_apb_csr_bank.md
SDRAM_APB_CSR_BANK -- requirements
Module: sdram_apb_csr_bank

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PADDR_SIZE, 8: APB address width.
- PDATA_SIZE, 32: APB data width; legal values are 32 and 64.
- NUM_CSR, 4: number of RW CSRs; legal range 1..16.
- CSR_RESET, all-zero: packed NUM_CSR*PDATA_SIZE reset values.
- INIT_DLY_CNT, 2500: power-up delay in cycles, 1 or more.
- COMMIT_TIMEOUT, 64: maximum cycles to wait for commit_ack_i.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1: sole clock, rising edge.
- PRESETn, in, 1: reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE, in, 1 each: APB controls.
- PADDR, in, PADDR_SIZE: byte address.
- PSTRB, in, PDATA_SIZE/8: write byte strobes.
- PPROT, in, 3: protection; bit 0 set means privileged.
- PWDATA, in, PDATA_SIZE: write data.
- PRDATA, out, PDATA_SIZE: read data.
- PREADY, out, 1: transfer complete.
- PSLVERR, out, 1: transfer error.
- csr_o, out, NUM_CSR*PDATA_SIZE: CSR contents; CSR k occupies slice k.
- status_i, in, PDATA_SIZE: read-only status.
- commit_req_o, out, 1: request to consumer to capture csr_o.
- commit_ack_i, in, 1: consumer has captured csr_o.
- init_done_o, out, 1: power-up delay elapsed.

Function
REQ-003 Register index SHALL be PADDR[PADDR_SIZE-1:log2(PDATA_SIZE/8)]; PADDR low bits SHALL be ignored.
REQ-004 Address map SHALL be:
- Indices 0..NUM_CSR-1: RW CSRs.
- Index NUM_CSR: STATUS, reading {init_done_o, status_i[PDATA_SIZE-2:0]}.
- Any other index: unmapped.
REQ-005 CSR0 bit PDATA_SIZE-1 SHALL be PP (privilege protect); writes SHALL write 0 to PP while init_done_o=0.
REQ-006 An access SHALL be an error when any of the following holds:
- PP=1 and PPROT[0]=0;
- the index is unmapped;
- it is a write to STATUS.
REQ-007 An error access SHALL complete with zero wait states: PREADY=1 and PSLVERR=1 in the access phase, PRDATA=0, no register or commit state changed.
REQ-008 A valid read SHALL complete with zero wait states, with PRDATA registered from the setup phase (PSEL=1, PENABLE=0) and PSLVERR=0.
REQ-009 Write FSM states SHALL be IDLE, WRITE, COMMIT and DONE; PREADY=1 only in IDLE and DONE.
REQ-010 FSM transitions SHALL be:
- IDLE -> WRITE on the setup phase of a valid write.
- WRITE -> COMMIT at the first access-phase cycle. In that cycle each byte of the addressed CSR with PSTRB set SHALL update; other bytes SHALL hold.
- COMMIT -> DONE when commit_ack_i=1 is sampled, or when COMMIT_TIMEOUT cycles have elapsed in COMMIT.
- DONE -> IDLE unconditionally.
REQ-011 commit_req_o SHALL be 1 exactly while in COMMIT; csr_o SHALL be stable throughout COMMIT.
REQ-012 PSLVERR SHALL be 1 in DONE only when COMMIT exited by timeout; the CSR update SHALL be retained regardless.
REQ-013 The timeout counter SHALL clear on entry to COMMIT. An ack and the timeout in the same cycle SHALL count as ack: no error.
REQ-014 commit_ack_i SHALL be ignored outside COMMIT.
REQ-015 Write latency SHALL be fixed: with ack sampled on the first COMMIT cycle, PREADY=1 on the 3rd cycle after the setup phase.
REQ-016 PSEL=0 while in WRITE (protocol violation) SHALL return the FSM to IDLE with no update and no commit.
REQ-017 The init counter SHALL load INIT_DLY_CNT at reset and decrement each cycle until init_done_o=1. init_done_o SHALL set in the cycle after the counter reaches 0, i.e. INIT_DLY_CNT+1 cycles after reset release, and SHALL stay set.
REQ-018 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-019 While PRESETn=0 the block SHALL hold:
- FSM in IDLE;
- PREADY=1, PSLVERR=0, PRDATA=0;
- commit_req_o=0, init_done_o=0;
- csr_o=CSR_RESET.
REQ-020 Reset asserted mid-write, including in COMMIT, SHALL abort immediately: commit_req_o=0, and the CSR returns to its reset value.

Verification
REQ-021 Release reset with INIT_DLY_CNT=10 -> init_done_o rises exactly 11 PCLK cycles later.
REQ-022 Write CSR1=0xA5A5_5A5A with PSTRB=0b0101, ack on the first COMMIT cycle -> CSR1=0x00A5_005A, one commit_req_o pulse, PREADY low for 2 cycles, PSLVERR=0.
REQ-023 Write CSR0 PP=1 after init_done_o, then an unprivileged read of CSR0 -> PSLVERR=1, PRDATA=0; a privileged read returns PP=1.
REQ-024 Write with commit_ack_i held at 0 and COMMIT_TIMEOUT=8 -> commit_req_o high for 8 cycles, then PREADY=1 with PSLVERR=1, CSR updated.
REQ-025 Read of index NUM_CSR+1, and a write to STATUS -> zero-wait PSLVERR=1, csr_o unchanged, no commit_req_o.
REQ-026 Assert PRESETn=0 during COMMIT -> commit_req_o=0 and csr_o=CSR_RESET immediately, FSM in IDLE after release.
